// File: rtl/quad_sum_pkg.sv
// Shared constants, payload type and lane helpers for the quad SIMD adder
// datapath. The adder wrapper and the unpacker both import this package so
// that lane width, lane count and the saturation value stay in one place.
package quad_sum_pkg;

    localparam int unsigned LANE_W     = 12;
    localparam int unsigned NLANES     = 4;
    localparam int unsigned SUM_W      = LANE_W + 1;
    localparam int unsigned WORD_W     = LANE_W * NLANES;
    localparam int unsigned IDX_W      = $clog2(NLANES);
    localparam int unsigned OVF_W      = 16;
    localparam int unsigned FIFO_DEPTH = 2;

    localparam logic [SUM_W-1:0] SAT_VALUE = 13'h0FFF;
    localparam logic [OVF_W-1:0] OVF_MAX   = '1;

    // One adder result word: four lane carries on top of the packed lane sums.
    typedef struct packed {
        logic [NLANES-1:0] carry;
        logic [WORD_W-1:0] p;
    } sum_word_t;

    typedef logic [IDX_W-1:0] lane_idx_t;

    // Raw 13-bit lane sum {carry_k, p_k} for lane idx of a word.
    function automatic logic [SUM_W-1:0] lane_sum(input sum_word_t w, input lane_idx_t idx);
        logic [LANE_W-1:0] lane;
        lane = '0;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (idx == IDX_W'(k)) begin
                lane = w.p[k*LANE_W +: LANE_W];
            end
        end
        return {w.carry[idx], lane};
    endfunction

    // Clamp a carry-set lane sum to the largest 12-bit value.
    function automatic logic [SUM_W-1:0] lane_clamp(input logic [SUM_W-1:0] s);
        return s[SUM_W-1] ? SAT_VALUE : s;
    endfunction

endpackage

// File: rtl/quad_word_fifo2.sv
// Two-entry synchronous word buffer between the adder and the lane replay.
// Occupancy-counted full/empty; a push while full is dropped even if the
// head pops in the same cycle (no pass-through), so the writer must honour
// full_o.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, empties the buffer
//   push_i  : write data_i at the tail
//   data_i  : word to store
//   pop_i   : retire the head entry
//   head_o  : current head entry (valid while empty_o is low)
//   full_o  : occupancy == depth
//   empty_o : occupancy == 0
module quad_word_fifo2
    import quad_sum_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  sum_word_t data_i,
    input  logic      pop_i,
    output sum_word_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    sum_word_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Guards decided from registered occupancy only.
    assign do_push = push_i && (count_q != CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only observed while non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/quad_sum_unpack.sv
// Replays one packed quad-adder result word as four consecutive 13-bit lane
// sums, lane 0 first, with a two-word buffer to absorb downstream stalls.
// With SATURATE set, carry-set lanes are clamped to 12 bits and each clamped
// lane is counted once, on the cycle it is handed off.
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   P_IN       : packed lane sums, lane k at [12k +: 12]
//   CARRY_IN   : lane carries, bit k for lane k
//   P_VALID    : word offered
//   P_READY    : word accepted this cycle when P_VALID is high
//   LANE_OUT   : current lane sum (0 while LANE_VALID is low)
//   LANE_IDX   : lane number of LANE_OUT
//   LANE_LAST  : LANE_OUT is lane 3
//   LANE_VALID : LANE_OUT valid
//   LANE_READY : downstream takes LANE_OUT
//   OVF_COUNT  : clamped-lane handoffs since reset, sticks at all-ones
module quad_sum_unpack
    import quad_sum_pkg::*;
#(
    parameter bit SATURATE = 1'b0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [WORD_W-1:0] P_IN,
    input  logic [NLANES-1:0] CARRY_IN,
    input  logic              P_VALID,
    output logic              P_READY,
    output logic [SUM_W-1:0]  LANE_OUT,
    output logic [IDX_W-1:0]  LANE_IDX,
    output logic              LANE_LAST,
    output logic              LANE_VALID,
    input  logic              LANE_READY,
    output logic [OVF_W-1:0]  OVF_COUNT
);

    sum_word_t        in_word;
    sum_word_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             lane_hs;
    logic             at_last_lane;
    logic [SUM_W-1:0] lane_raw;
    logic             lane_carry;
    logic             count_ovf;

    lane_idx_t        idx_q, idx_d;
    logic [OVF_W-1:0] ovf_q, ovf_d;

    assign in_word.carry = CARRY_IN;
    assign in_word.p     = P_IN;

    // Readiness depends only on buffer occupancy and reset, never on LANE_READY.
    assign P_READY = ~fifo_full & ~RST;
    assign push    = P_VALID & P_READY;

    quad_word_fifo2 u_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (push),
        .data_i  (in_word),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Lane handoff; the head word retires with its last lane.
    assign lane_hs      = LANE_VALID & LANE_READY;
    assign at_last_lane = (idx_q == IDX_W'(NLANES - 1));
    assign pop          = lane_hs & at_last_lane;

    assign lane_raw   = lane_sum(head, idx_q);
    assign lane_carry = lane_raw[SUM_W-1];
    assign count_ovf  = SATURATE && lane_hs && lane_carry;

    // Lane counter and overflow counter next state.
    always_comb begin
        idx_d = idx_q;
        ovf_d = ovf_q;
        if (lane_hs) begin
            idx_d = at_last_lane ? '0 : idx_q + IDX_W'(1);
        end
        if (count_ovf && (ovf_q != OVF_MAX)) begin
            ovf_d = ovf_q + OVF_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q <= '0;
            ovf_q <= '0;
        end else begin
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

    // Lane outputs come from registered state through the head mux only.
    always_comb begin
        LANE_OUT = '0;
        if (LANE_VALID) begin
            LANE_OUT = SATURATE ? lane_clamp(lane_raw) : lane_raw;
        end
    end

    assign LANE_VALID = ~fifo_empty;
    assign LANE_IDX   = idx_q;
    assign LANE_LAST  = LANE_VALID & at_last_lane;
    assign OVF_COUNT  = ovf_q;

endmodule

// File: tb/tb_quad_sum_unpack.sv
module tb_quad_sum_unpack;

    logic        CLK = 1'b0;
    logic        rst;
    logic [47:0] p_in;
    logic [3:0]  c_in;
    logic        p_valid;
    logic        l_ready;

    logic        rdy0, vld0, last0, rdy1, vld1, last1;
    logic [12:0] out0, out1;
    logic [1:0]  idx0, idx1;
    logic [15:0] ovf0, ovf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    quad_sum_unpack #(.SATURATE(1'b0)) dut0 (
        .CLK(CLK), .RST(rst), .P_IN(p_in), .CARRY_IN(c_in), .P_VALID(p_valid),
        .P_READY(rdy0), .LANE_OUT(out0), .LANE_IDX(idx0), .LANE_LAST(last0),
        .LANE_VALID(vld0), .LANE_READY(l_ready), .OVF_COUNT(ovf0)
    );

    quad_sum_unpack #(.SATURATE(1'b1)) dut1 (
        .CLK(CLK), .RST(rst), .P_IN(p_in), .CARRY_IN(c_in), .P_VALID(p_valid),
        .P_READY(rdy1), .LANE_OUT(out1), .LANE_IDX(idx1), .LANE_LAST(last1),
        .LANE_VALID(vld1), .LANE_READY(l_ready), .OVF_COUNT(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word with lane k = base + k.
    function automatic logic [47:0] mk_word(input int base);
        logic [47:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            w[12*k +: 12] = 12'(base + k);
        end
        return w;
    endfunction

    // Behavioural model: a queue of whole words, a lane position, a counter.
    logic [51:0] mq[$];
    int          midx = 0;
    int          movf = 0;
    bit          started = 1'b0;
    bit          m_vld, m_acc;
    logic [3:0]  m_carry;

    function automatic logic [12:0] exp_lane(input logic [51:0] w, input int idx, input bit sat);
        logic [47:0] p;
        logic [3:0]  c;
        int          v;
        p = w[47:0];
        c = w[51:48];
        v = int'((p >> (12 * idx)) & 48'hFFF);
        if (c[idx]) begin
            if (sat) return 13'h0FFF;
            v = v + 4096;
        end
        return 13'(v);
    endfunction

    always @(posedge CLK) begin
        if (rst) begin
            mq.delete();
            midx = 0;
            movf = 0;
            started = 1'b1;
        end else if (started) begin
            m_vld = (mq.size() > 0);
            m_acc = p_valid && (mq.size() < 2);
            if (m_vld && l_ready) begin
                m_carry = mq[0][51:48];
                if (m_carry[midx] && movf < 65535) movf++;
                if (midx == 3) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else begin
                    midx++;
                end
            end
            if (m_acc) mq.push_back({c_in, p_in});
        end
    end

    task automatic check_inst(input string tag, input bit sat, input logic rdy, input logic vld,
                              input logic last, input logic [1:0] idx, input logic [12:0] out,
                              input logic [15:0] ovf);
        bit ev;
        ev = (mq.size() > 0);
        chk({tag, "_ready"}, 32'(rdy), 32'(!rst && mq.size() < 2));
        chk({tag, "_valid"}, 32'(vld), 32'(ev));
        chk({tag, "_idx"},   32'(idx), 32'(midx));
        chk({tag, "_last"},  32'(last), 32'(midx == 3));
        chk({tag, "_ovf"},   32'(ovf), sat ? 32'(movf) : 32'd0);
        if (ev) chk({tag, "_lane"}, 32'(out), 32'(exp_lane(mq[0], midx, sat)));
    endtask

    always @(negedge CLK) begin
        if (started) begin
            check_inst("m0", 1'b0, rdy0, vld0, last0, idx0, out0, ovf0);
            check_inst("m1", 1'b1, rdy1, vld1, last1, idx1, out1, ovf1);
        end
    end

    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    logic [12:0] exp0 [4];
    int n;
    bit acc;

    initial begin
        rst = 1'b1; p_in = '0; c_in = '0; p_valid = 1'b0; l_ready = 1'b0;
        exp0 = '{13'h0FFF, 13'h1FFF, 13'h0FFF, 13'h1FFF};

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rst_ready", 32'(rdy0), 32'd0);
        chk("rst_valid", 32'(vld0), 32'd0);
        chk("rst_out",   32'(out0), 32'd0);
        chk("rst_last",  32'(last1), 32'd0);
        chk("rst_ovf",   32'(ovf1), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("ready_after_rst", 32'(rdy0), 32'd1);

        // Single word, full rate
        l_ready = 1'b1;
        p_in = 48'h003_002_001_000; c_in = 4'b0000; p_valid = 1'b1;
        @(posedge CLK); #1;
        p_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("single_valid", 32'(vld0), 32'd1);
            chk("single_idx",   32'(idx0), 32'(k));
            chk("single_lane",  32'(out0), 32'(k));
            chk("single_last",  32'(last0), 32'(k == 3));
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("single_drained", 32'(vld0), 32'd0);
        @(posedge CLK); #1;

        // Backpressure: three words against a stalled consumer
        l_ready = 1'b0;
        p_in = mk_word(12'h100); p_valid = 1'b1;
        @(posedge CLK); #1;
        p_in = mk_word(12'h104);
        @(negedge CLK);
        chk("bp_ready_one", 32'(rdy0), 32'd1);
        @(posedge CLK); #1;
        p_in = mk_word(12'h108);
        repeat (3) begin
            @(negedge CLK);
            chk("bp_ready_full", 32'(rdy0), 32'd0);
            chk("bp_hold_lane",  32'(out0), 32'h100);
            chk("bp_hold_idx",   32'(idx0), 32'd0);
            @(posedge CLK); #1;
        end
        l_ready = 1'b1;
        n = 0;
        for (int cyc = 0; cyc < 40 && n < 12; cyc++) begin
            @(negedge CLK);
            acc = p_valid && rdy0;
            if (vld0) begin
                chk("bp_lane", 32'(out0), 32'(12'h100 + n));
                n++;
            end
            @(posedge CLK); #1;
            if (acc) p_valid = 1'b0;
        end
        chk("bp_lane_count", 32'(n), 32'd12);
        @(negedge CLK);
        chk("bp_drained", 32'(vld0), 32'd0);
        @(posedge CLK); #1;

        // Carries with and without saturation, consumer toggling
        p_in = 48'hFFF_FFF_FFF_FFF; c_in = 4'b1010; p_valid = 1'b1;
        @(posedge CLK); #1;
        p_valid = 1'b0; c_in = 4'b0000;
        n = 0;
        for (int cyc = 0; cyc < 16 && n < 4; cyc++) begin
            @(negedge CLK);
            if (vld0 && l_ready) begin
                chk("raw_lane", 32'(out0), 32'(exp0[n]));
                chk("sat_lane", 32'(out1), 32'h0FFF);
                n++;
            end
            @(posedge CLK); #1;
            l_ready = ~l_ready;
        end
        l_ready = 1'b1;
        chk("sat_lane_count", 32'(n), 32'd4);
        @(negedge CLK);
        chk("sat_ovf",  32'(ovf1), 32'd2);
        chk("raw_ovf",  32'(ovf0), 32'd0);
        @(posedge CLK); #1;

        // Sustained rate: one word every four cycles
        for (int w = 0; w < 100; w++) begin
            p_in = mk_word(12'h200 + 4 * (w % 64)); c_in = 4'(w); p_valid = 1'b1;
            @(negedge CLK);
            chk("rate_ready", 32'(rdy0), 32'd1);
            if (w > 0) chk("rate_contig", 32'(vld0), 32'd1);
            @(posedge CLK); #1;
            p_valid = 1'b0;
            repeat (3) begin
                @(negedge CLK);
                chk("rate_contig", 32'(vld0), 32'd1);
                @(posedge CLK); #1;
            end
        end
        @(negedge CLK);
        chk("rate_tail_last", 32'(last0), 32'd1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rate_drained", 32'(vld0), 32'd0);
        @(posedge CLK); #1;

        // Reset mid-word with a second word buffered
        p_in = mk_word(12'h300); c_in = 4'b1111; p_valid = 1'b1;
        @(posedge CLK); #1;
        p_in = mk_word(12'h400); c_in = 4'b0000;
        @(negedge CLK);
        chk("mid_lane0_raw", 32'(out0), 32'h1300);
        chk("mid_lane0_sat", 32'(out1), 32'h0FFF);
        @(posedge CLK); #1;
        p_valid = 1'b0;
        @(negedge CLK);
        chk("mid_lane1_idx", 32'(idx0), 32'd1);
        chk("mid_lane1_raw", 32'(out0), 32'h1301);
        @(posedge CLK); #1;
        rst = 1'b1;
        @(negedge CLK);
        chk("mid_rst_ready", 32'(rdy0), 32'd0);
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        chk("mid_post_valid", 32'(vld0), 32'd0);
        chk("mid_post_ovf",   32'(ovf1), 32'd0);
        chk("mid_post_ready", 32'(rdy0), 32'd1);
        repeat (3) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk("mid_no_stale", 32'(vld1), 32'd0);
        end
        p_in = mk_word(12'h500); p_valid = 1'b1;
        @(posedge CLK); #1;
        p_valid = 1'b0;
        @(negedge CLK);
        chk("mid_new_idx",  32'(idx0), 32'd0);
        chk("mid_new_lane", 32'(out0), 32'h500);
        repeat (6) @(posedge CLK);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
